// File: rtl/led_pattern_engine.sv
// LED pattern engine: command/payload interface driving LEDs in static, blink or PWM mode.
// Commands execute on the rising edge of en_i; every command answers with ack_o (plus err_o if rejected).
module led_pattern_engine #(
  parameter int LED_WIDTH      = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int CALLBACK_WIDTH = 8,
  parameter int PRESC_DIV      = 1024
) (
  input  logic                      clk,
  input  logic                      rst_ni,
  input  logic [3:0]                cmd_i,
  input  logic [DATA_WIDTH-1:0]     led_payload_i,
  input  logic                      en_i,
  output logic [CALLBACK_WIDTH-1:0] callback_o,
  output logic                      ack_o,
  output logic                      err_o,
  output logic [LED_WIDTH-1:0]      led_o
);

  localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_DIV - 1);

  localparam logic [3:0] CMD_SET_LED    = 4'h1;
  localparam logic [3:0] CMD_SET_MODE   = 4'h2;
  localparam logic [3:0] CMD_SET_DUTY   = 4'h3;
  localparam logic [3:0] CMD_SET_PERIOD = 4'h4;
  localparam logic [3:0] CMD_GET        = 4'h5;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_PWM    = 2'd2
  } mode_t;

  logic                  en_r;
  logic                  en_d;
  logic [3:0]            cmd_r;
  logic [DATA_WIDTH-1:0] payload_r;
  logic                  exec;

  logic [LED_WIDTH-1:0]  pattern_q;
  mode_t                 mode_q;
  logic [1:0]            mode_bits;
  logic [DATA_WIDTH-1:0] duty_q;
  logic [DATA_WIDTH-1:0] period_q;

  logic [PW-1:0]         presc_q;
  logic                  tick;
  logic [DATA_WIDTH-1:0] pwm_cnt_q;
  logic [DATA_WIDTH-1:0] blink_cnt_q;
  logic                  phase_q;

  logic                      wr_led;
  logic                      wr_mode;
  logic                      wr_duty;
  logic                      wr_period;
  logic                      cmd_err;
  logic [CALLBACK_WIDTH-1:0] cb_next;
  logic                      restart_all;
  logic                      restart_blink;
  logic [LED_WIDTH-1:0]      led_target;

  // Operands are frozen at the rising edge so a held strobe cannot alter them.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      en_r      <= 1'b0;
      en_d      <= 1'b0;
      cmd_r     <= '0;
      payload_r <= '0;
    end else begin
      en_r <= en_i;
      en_d <= en_r;
      if (en_i && !en_r) begin
        cmd_r     <= cmd_i;
        payload_r <= led_payload_i;
      end
    end
  end

  assign exec      = en_r & ~en_d;
  assign mode_bits = mode_q;

  always_comb begin
    wr_led    = 1'b0;
    wr_mode   = 1'b0;
    wr_duty   = 1'b0;
    wr_period = 1'b0;
    cmd_err   = 1'b0;
    cb_next   = '0;
    case (cmd_r)
      CMD_SET_LED: begin
        wr_led  = 1'b1;
        cb_next = CALLBACK_WIDTH'(payload_r);
      end
      CMD_SET_MODE: begin
        if (payload_r[1:0] == 2'd3) begin
          cmd_err = 1'b1;
          cb_next = CALLBACK_WIDTH'(mode_bits);
        end else begin
          wr_mode = 1'b1;
          cb_next = CALLBACK_WIDTH'(payload_r[1:0]);
        end
      end
      CMD_SET_DUTY: begin
        wr_duty = 1'b1;
        cb_next = CALLBACK_WIDTH'(payload_r);
      end
      CMD_SET_PERIOD: begin
        wr_period = 1'b1;
        cb_next   = CALLBACK_WIDTH'(payload_r);
      end
      CMD_GET: begin
        case (payload_r[1:0])
          2'd0:    cb_next = CALLBACK_WIDTH'(pattern_q);
          2'd1:    cb_next = CALLBACK_WIDTH'(mode_bits);
          2'd2:    cb_next = CALLBACK_WIDTH'(duty_q);
          default: cb_next = CALLBACK_WIDTH'(period_q);
        endcase
      end
      default: begin
        cmd_err = 1'b1;
        cb_next = '1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      pattern_q <= '0;
      mode_q    <= MODE_STATIC;
      duty_q    <= '0;
      period_q  <= '0;
    end else if (exec) begin
      if (wr_led)    pattern_q <= LED_WIDTH'(payload_r);
      if (wr_mode)   mode_q    <= mode_t'(payload_r[1:0]);
      if (wr_duty)   duty_q    <= payload_r;
      if (wr_period) period_q  <= payload_r;
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      callback_o <= '0;
      ack_o      <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      ack_o <= exec;
      err_o <= exec & cmd_err;
      if (exec) callback_o <= cb_next;
    end
  end

  assign tick          = (presc_q == PRESC_LAST);
  assign restart_all   = exec & wr_mode;
  assign restart_blink = exec & wr_period;

  // A restart wins over a coincident tick, so the cleared counters start clean.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
    end else if (restart_all) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
    end else if (tick) begin
      presc_q   <= '0;
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
    end else begin
      presc_q   <= presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (restart_all || restart_blink) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (tick) begin
      if (blink_cnt_q == period_q) begin
        blink_cnt_q <= '0;
        phase_q     <= ~phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    led_target = pattern_q;
    case (mode_q)
      MODE_BLINK: led_target = phase_q ? pattern_q : '0;
      MODE_PWM:   led_target = pattern_q & {LED_WIDTH{pwm_cnt_q < duty_q}};
      default:    led_target = pattern_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) led_o <= '0;
    else         led_o <= led_target;
  end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed bench for led_pattern_engine: PRESC_DIV=4 instance for blink/handshake, PRESC_DIV=1 for PWM.
module tb_led_pattern_engine;

  logic       clk;
  logic       rst_ni;
  logic [3:0] cmd_i;
  logic [7:0] led_payload_i;
  logic       en_i;

  logic [7:0] cb4, led4, cb1, led1;
  logic       ack4, err4, ack1, err1;

  int n_chk  = 0;
  int n_fail = 0;

  led_pattern_engine #(.LED_WIDTH(8), .DATA_WIDTH(8), .CALLBACK_WIDTH(8), .PRESC_DIV(4)) u_dut4 (
    .clk(clk), .rst_ni(rst_ni), .cmd_i(cmd_i), .led_payload_i(led_payload_i), .en_i(en_i),
    .callback_o(cb4), .ack_o(ack4), .err_o(err4), .led_o(led4));

  led_pattern_engine #(.LED_WIDTH(8), .DATA_WIDTH(8), .CALLBACK_WIDTH(8), .PRESC_DIV(1)) u_dut1 (
    .clk(clk), .rst_ni(rst_ni), .cmd_i(cmd_i), .led_payload_i(led_payload_i), .en_i(en_i),
    .callback_o(cb1), .ack_o(ack1), .err_o(err1), .led_o(led1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One-cycle strobe; returns 1ns after the execute edge (k+1).
  task automatic send(input logic [3:0] c, input logic [7:0] p);
    @(negedge clk);
    cmd_i = c; led_payload_i = p; en_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic count_lit(input int cycles, output int lit);
    lit = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (led1 == 8'h0F) lit++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    int lit;
    rst_ni = 1'b0; en_i = 1'b0; cmd_i = 4'h0; led_payload_i = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_led", led4, 8'h00);
    chk("rst_cb", cb4, 8'h00);
    chk("rst_ack", ack4, 1'b0);
    chk("rst_err", err4, 1'b0);
    @(negedge clk);
    rst_ni = 1'b1;

    // SET_LED 0xA5 with the strobe held for five cycles
    @(negedge clk);
    cmd_i = 4'h1; led_payload_i = 8'hA5; en_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    led_payload_i = 8'h3C;
    @(posedge clk); #1;
    chk("hold_ack", ack4, 1'b1);
    chk("hold_cb", cb4, 8'hA5);
    chk("hold_err", err4, 1'b0);
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      acks += int'(ack4);
      if (i == 0) chk("hold_led_k2", led4, 8'hA5);
      if (i == 2) en_i = 1'b0;
    end
    chk("hold_extra_acks", acks, 0);
    send(4'h5, 8'h00);
    chk("get_pattern", cb4, 8'hA5);

    // errors
    send(4'h2, 8'h02);
    chk("mode2_cb", cb4, 8'h02);
    chk("mode2_err", err4, 1'b0);
    send(4'h2, 8'h03);
    chk("mode3_ack", ack4, 1'b1);
    chk("mode3_err", err4, 1'b1);
    send(4'h5, 8'h01);
    chk("mode3_unchanged", cb4, 8'h02);
    send(4'h7, 8'h12);
    chk("cmd7_ack", ack4, 1'b1);
    chk("cmd7_err", err4, 1'b1);
    chk("cmd7_cb", cb4, 8'hFF);
    @(posedge clk); #1;
    chk("err_pulse_len", err4, 1'b0);
    send(4'h5, 8'h00);
    chk("cmd7_state_kept", cb4, 8'hA5);
    send(4'h0, 8'h55);
    chk("cmd0_err", err4, 1'b1);
    chk("cmd0_cb", cb4, 8'hFF);

    // back-to-back SET_DUTY 10 / GET 2
    @(negedge clk);
    cmd_i = 4'h3; led_payload_i = 8'd10; en_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en_i = 1'b0;
    @(posedge clk); #1;
    chk("b2b_ack1", ack4, 1'b1);
    chk("b2b_cb1", cb4, 8'd10);
    @(negedge clk);
    cmd_i = 4'h5; led_payload_i = 8'd2; en_i = 1'b1;
    @(posedge clk); #1;
    chk("b2b_gap", ack4, 1'b0);
    @(negedge clk);
    en_i = 1'b0;
    @(posedge clk); #1;
    chk("b2b_ack2", ack4, 1'b1);
    chk("b2b_cb2", cb4, 8'd10);
    send(4'h5, 8'h03);
    chk("get_period_rst", cb4, 8'h00);

    // blink, PRESC_DIV=4, period 2 -> 12-cycle half period
    send(4'h1, 8'hFF);
    send(4'h4, 8'h02);
    send(4'h2, 8'h01);
    chk("blink_mode_cb", cb4, 8'h01);
    repeat (12) @(posedge clk);
    #1;
    chk("blink_e12", led4, 8'h00);
    @(posedge clk); #1;
    chk("blink_e13", led4, 8'hFF);
    send(4'h4, 8'h02);
    chk("blink_p0", led4, 8'hFF);
    @(posedge clk); #1;
    chk("blink_restart", led4, 8'h00);
    repeat (8) @(posedge clk);
    #1;
    chk("blink_p9", led4, 8'h00);
    @(posedge clk); #1;
    chk("blink_p10", led4, 8'hFF);

    // asynchronous reset mid-blink
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_led", led4, 8'h00);
    chk("async_cb", cb4, 8'h00);
    chk("async_ack", ack4, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    send(4'h5, 8'h01);
    chk("post_rst_mode", cb4, 8'h00);
    send(4'h5, 8'h00);
    chk("post_rst_pattern", cb4, 8'h00);

    // PWM, PRESC_DIV=1, pattern 0x0F
    send(4'h1, 8'h0F);
    send(4'h3, 8'd64);
    send(4'h2, 8'h02);
    @(posedge clk); #1;
    chk("pwm_e1", led1, 8'h0F);
    repeat (63) @(posedge clk);
    #1;
    chk("pwm_e64", led1, 8'h0F);
    @(posedge clk); #1;
    chk("pwm_e65", led1, 8'h00);
    count_lit(256, lit);
    chk("pwm_duty64", lit, 64);
    send(4'h3, 8'd0);
    count_lit(256, lit);
    chk("pwm_duty0", lit, 0);
    send(4'h3, 8'd255);
    count_lit(256, lit);
    chk("pwm_duty255", lit, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pattern_engine.md
Name: led_pattern_engine

Overview:
- Parametrised successor to the single-pattern LED controller in pdh_core.
- Drives LED_WIDTH board LEDs from a command/payload interface, with three output modes: static, blink and PWM dimming.
- Adds a command-readback path, an ack/error handshake, and edge-detected command execution.
- Sits behind the pdh_core command decoder; callback_o is returned to the PS-side status path.

Parameters:
- LED_WIDTH, 8, number of LED outputs.
- DATA_WIDTH, 8, payload width; also the width of the duty, period and PWM counters.
- CALLBACK_WIDTH, 8, response width; must be >= max(LED_WIDTH, DATA_WIDTH); responses are zero-extended.
- PRESC_DIV, 1024, clk cycles per tick (>=1); sets the blink/PWM timebase.

Ports:
- clk  input  1  system clock.
- rst_ni  input  1  asynchronous active-low reset (this is decided).
- cmd_i  input  4  command opcode.
- led_payload_i  input  DATA_WIDTH  command argument.
- en_i  input  1  command strobe; level input, rising-edge executed.
- callback_o  output  CALLBACK_WIDTH  response word; held until the next command.
- ack_o  output  1  one-cycle pulse when a command completes.
- err_o  output  1  one-cycle pulse, coincident with ack_o, for a rejected command.
- led_o  output  LED_WIDTH  registered LED drive.

Behaviour:
- Reset (async assert, sync release): all registers clear.
  - Outputs: led_o=0, callback_o=0, ack_o=0, err_o=0.
  - Config: pattern=0, mode=STATIC, duty=0, period=0.
  - Counters: prescaler=0, pwm_cnt=0, blink_cnt=0, phase=0.
  - Reset mid-command aborts the command; no ack is issued.
- Input stage:
  - Edge k samples en_i into en_r and captures cmd_i/led_payload_i into cmd_r/payload_r.
  - en_d is en_r delayed by one cycle.
  - Execute condition is en_r & ~en_d, so holding en_i high runs exactly one command.
  - Payload is captured only on the edge where en_i rises.
- Execute: at edge k+1 the config register updates and callback_o, ack_o and err_o are registered. ack_o is high for exactly that one cycle.
- Commands:
  - 0x1 SET_LED: pattern <= payload[LED_WIDTH-1:0]; callback = payload.
  - 0x2 SET_MODE: payload[1:0] selects 0=STATIC, 1=BLINK, 2=PWM; value 3 gives err, mode unchanged. Callback = new mode.
  - 0x3 SET_DUTY: duty <= payload; callback = payload.
  - 0x4 SET_PERIOD: period <= payload; callback = payload.
  - 0x5 GET: payload[1:0] selects 0=pattern, 1=mode, 2=duty, 3=period; callback = selected register; no state change.
  - 0x0 and 0x6..0xF: err; callback = all ones; no state change.
- Tick:
  - Prescaler counts 0..PRESC_DIV-1 and wraps.
  - tick pulses for one cycle when the count reaches PRESC_DIV-1.
  - PRESC_DIV=1 means tick every cycle.
- BLINK:
  - blink_cnt increments on tick.
  - On a tick with blink_cnt==period, blink_cnt <= 0 and phase toggles.
  - Half-period = (period+1) ticks.
  - Output target = pattern when phase=1, else 0.
- PWM:
  - pwm_cnt increments on tick and wraps at 2^DATA_WIDTH-1 -> 0.
  - Output target[i] = pattern[i] & (pwm_cnt < duty).
  - duty=0 gives always off; duty=2^DATA_WIDTH-1 gives off for one tick per frame.
- STATIC: output target = pattern.
- Counter restarts:
  - A successful SET_MODE (even to the same mode) clears the prescaler, pwm_cnt, blink_cnt and phase.
  - SET_PERIOD clears blink_cnt and phase.
  - SET_DUTY does not restart pwm_cnt.
- Output register: led_o is registered from the output target. A config change at edge k+1 appears on led_o at edge k+2.
- Boundaries:
  - en_i rising on the cycle ack_o is high is accepted normally.
  - Back-to-back commands are possible every 2 cycles (en_i high 1 cycle, low 1 cycle).
  - A command arriving while the last tick fires takes priority: counters clear, with no increment that cycle.

Test Plan:
- Reset: drive rst_ni low asynchronously mid-blink -> led_o=0, callback_o=0, ack_o=0 immediately; after release a GET of mode -> callback=0.
- SET_LED 0xA5 with en_i held high for 5 cycles:
  - Exactly one ack_o pulse, at edge k+1; callback=0xA5.
  - led_o=0xA5 at edge k+2.
  - Follow-up GET 0 -> callback=0xA5.
- BLINK with PRESC_DIV=4, pattern 0xFF, period 2 -> led_o alternates 0x00/0xFF every 12 cycles; SET_PERIOD mid-phase restarts led_o at 0x00.
- PWM with PRESC_DIV=1, pattern 0x0F, duty 64 -> led_o=0x0F for 64 of every 256 cycles; duty 0 -> never lit; duty 255 -> lit 255/256.
- Errors: cmd 0x7 -> ack_o and err_o together, callback=0xFF, state unchanged; SET_MODE 3 -> err_o, mode read back unchanged.
- Back-to-back SET_DUTY 10 then GET 2 with a 1-cycle en_i gap -> two acks 2 cycles apart; second callback=10.
